vga_sync_timing: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 26 ++
 rtl/vga_sync_timing.sv | 95 +++++++++
 tb/tb_vga_sync_timing.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 porch/sync constants, derived totals and sync windows
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_DISPLAY  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_PIPE_DELAY = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    function automatic logic in_window(input logic [9:0] cnt, input int lo, input int len);
        return int'(cnt) >= lo && int'(cnt) < lo + len;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: WIDTH x DEPTH shift register with synchronous reset to RESET_VAL
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA raster counters with sync and colour aligned to a PIPE_DELAY-clk pixel generator
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       p_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || PIPE_DELAY < 1) begin : g_bad_div
        $error("vga_sync_timing: CLK_DIV and PIPE_DELAY must be at least 1");
    end

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt, v_cnt;
    logic          h_last, v_last, hs_raw, vs_raw, hs_d, vs_d, von_d;

    assign p_tick      = div_cnt == DW'(CLK_DIV - 1);
    assign h_last      = h_cnt == 10'(H_TOTAL - 1);
    assign v_last      = v_cnt == 10'(V_TOTAL - 1);
    assign line_start  = p_tick && h_last;
    assign frame_start = line_start && v_last;
    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign video_on    = in_window(h_cnt, 0, H_DISPLAY) && in_window(v_cnt, 0, V_DISPLAY);
    assign hs_raw      = in_window(h_cnt, H_DISPLAY + H_FRONT, H_SYNC);
    assign vs_raw      = in_window(v_cnt, V_DISPLAY + V_FRONT, V_SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
            if (p_tick) begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Flushing to "not asserted" guarantees no partial sync pulse after reset
    sync_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE_DELAY),
        .RESET_VAL(3'b000)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .d    ({hs_raw, vs_raw, video_on}),
        .q    ({hs_d, vs_d, von_d})
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out <= 3'b000;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
        end else begin
            rgb_out <= von_d ? rgb_in : 3'b000;
            hsync   <= hs_d ? SYNC_POL : ~SYNC_POL;
            vsync   <= vs_d ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync_timing.sv
// tb_vga_sync_timing: three parameterisations checked against a closed-form raster model plus directed vectors
module tb_vga_sync_timing;

    typedef struct {int div, hd, hf, hs, hb, vd, vf, vs, vb, pd; logic pol;} cfg_t;
    typedef struct packed {logic [9:0] x, y; logic von, pt, ls, fs, hs, vs; logic [2:0] rgb;} obs_t;
    typedef struct {int c; obs_t o;} tv_t;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] rgb_in = 3'b000;
    logic [2:0] rgb_prev = 3'b000;
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       von [3], pt [3], ls [3], fs [3], hs [3], vs [3];
    logic [2:0] rgb [3];
    obs_t       act [3];
    cfg_t       cfg [3];
    longint     c [3];
    bit         valid [3];
    bit         count_en;
    int         total, passed;
    int hs_low0, ls0, tick0, hs_hi1, pt1, ls1, fs2, ls2, vs_low2, vt2, hs_low2;
    tv_t        tv [14];

    always #5 clk = ~clk;

    vga_sync_timing u_d0 (
        .clk(clk), .reset(rst[0]), .rgb_in(rgb_in), .pixel_x(px[0]), .pixel_y(py[0]),
        .video_on(von[0]), .p_tick(pt[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .rgb_out(rgb[0]));

    vga_sync_timing #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_d1 (
        .clk(clk), .reset(rst[1]), .rgb_in(rgb_in), .pixel_x(px[1]), .pixel_y(py[1]),
        .video_on(von[1]), .p_tick(pt[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .rgb_out(rgb[1]));

    vga_sync_timing #(.H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3), .V_DISPLAY(6),
                      .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3), .PIPE_DELAY(3)) u_d2 (
        .clk(clk), .reset(rst[2]), .rgb_in(rgb_in), .pixel_x(px[2]), .pixel_y(py[2]),
        .video_on(von[2]), .p_tick(pt[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .hsync(hs[2]), .vsync(vs[2]), .rgb_out(rgb[2]));

    always_comb
        for (int i = 0; i < 3; i++)
            act[i] = {px[i], py[i], von[i], pt[i], ls[i], fs[i], hs[i], vs[i], rgb[i]};

    // Raster position is pure arithmetic on clocks since reset; pins see that position PD+1 clks late
    function automatic obs_t model(input cfg_t p, input longint cc, input logic [2:0] rp);
        obs_t   o;
        longint t;
        int     ht, vt, h, v, hh, vv;
        logic   hsa, vsa, vond;
        ht = p.hd + p.hf + p.hs + p.hb;
        vt = p.vd + p.vf + p.vs + p.vb;
        t = cc / p.div;
        h = int'(t % ht);
        v = int'((t / ht) % vt);
        o.x = 10'(h);
        o.y = 10'(v);
        o.von = h < p.hd && v < p.vd;
        o.pt = (cc % p.div) == p.div - 1;
        o.ls = o.pt && h == ht - 1;
        o.fs = o.ls && v == vt - 1;
        hsa = 1'b0;
        vsa = 1'b0;
        vond = 1'b0;
        if (cc > p.pd) begin
            t = (cc - p.pd - 1) / p.div;
            hh = int'(t % ht);
            vv = int'((t / ht) % vt);
            hsa = hh >= p.hd + p.hf && hh < p.hd + p.hf + p.hs;
            vsa = vv >= p.vd + p.vf && vv < p.vd + p.vf + p.vs;
            vond = hh < p.hd && vv < p.vd;
        end
        o.hs = hsa ? p.pol : ~p.pol;
        o.vs = vsa ? p.pol : ~p.pol;
        o.rgb = vond ? rp : 3'b000;
        return o;
    endfunction

    function automatic tv_t mk(input int cc, input int x, input int y, input logic v_on,
                               input logic tick, input logic lstart, input logic hsy, input logic [2:0] col);
        tv_t r;
        r.c = cc;
        r.o = {10'(x), 10'(y), v_on, tick, lstart, 1'b0, hsy, 1'b1, col};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic step(input logic [2:0] nrst, input logic [2:0] nrgb);
        obs_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                c[i] = 0;
                valid[i] = 1'b1;
            end else begin
                c[i]++;
            end
        end
        rgb_prev = rgb_in;
        rst = nrst;
        rgb_in = nrgb;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (valid[i]) begin
                e = model(cfg[i], c[i], rgb_prev);
                chk($sformatf("model dut%0d c=%0d", i, c[i]), 64'(act[i]), 64'(e));
            end
        end
        if (count_en) begin
            if (c[0] < 1600) begin
                hs_low0 += int'(!hs[0]);
                ls0 += int'(ls[0]);
                tick0 += int'(pt[0]);
            end
            if (c[1] < 800) begin
                hs_hi1 += int'(hs[1]);
                pt1 += int'(pt[1]);
                ls1 += int'(ls[1]);
            end
            if (c[2] < 825) begin
                fs2 += int'(fs[2]);
                ls2 += int'(ls[2]);
                vs_low2 += int'(!vs[2]);
                vt2 += int'(pt[2] && von[2]);
                hs_low2 += int'(!hs[2]);
            end
        end
    endtask

    initial begin
        int n;
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
        cfg[1] = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b1};
        cfg[2] = '{3, 16, 2, 4, 3, 6, 1, 2, 2, 3, 1'b0};
        tv[0]  = mk(0,    0,   0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
        tv[1]  = mk(1,    0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tv[2]  = mk(2,    1,   0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
        tv[3]  = mk(3,    1,   0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        tv[4]  = mk(1279, 639, 0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        tv[5]  = mk(1282, 641, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        tv[6]  = mk(1283, 641, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        tv[7]  = mk(1314, 657, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tv[8]  = mk(1315, 657, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        tv[9]  = mk(1506, 753, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tv[10] = mk(1507, 753, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        tv[11] = mk(1599, 799, 0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        tv[12] = mk(1600, 0,   1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
        tv[13] = mk(1603, 1,   1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        repeat (4) step(3'b111, 3'b010);
        count_en = 1'b1;
        step(3'b000, 3'b010);
        for (int k = 0; k < 14; k++) begin
            while (c[0] < tv[k].c) step(3'b000, 3'b010);
            chk($sformatf("table c=%0d", tv[k].c), 64'(act[0]), 64'(tv[k].o));
        end
        count_en = 1'b0;
        chk("d0 hsync low clks per line", 64'(hs_low0), 64'(192));
        chk("d0 line_start per line", 64'(ls0), 64'(1));
        chk("d0 ticks per line", 64'(tick0), 64'(800));
        chk("d1 hsync high clks per line", 64'(hs_hi1), 64'(96));
        chk("d1 p_tick clks per line", 64'(pt1), 64'(800));
        chk("d1 line_start per line", 64'(ls1), 64'(1));
        chk("d2 frame_start per frame", 64'(fs2), 64'(1));
        chk("d2 line_start per frame", 64'(ls2), 64'(11));
        chk("d2 vsync low clks", 64'(vs_low2), 64'(150));
        chk("d2 visible ticks", 64'(vt2), 64'(96));
        chk("d2 hsync low clks", 64'(hs_low2), 64'(132));

        n = 0;
        while ((((c[0] + 1) / 2) % 800) != 700 && n < 2000) begin
            step(3'b000, 3'($urandom));
            n++;
        end
        chk("d0 reached h=700", 64'(n < 2000), 64'(1));
        step(3'b001, 3'($urandom));
        step(3'b000, 3'($urandom));
        chk("d0 pixel_x after reset", 64'(px[0]), 64'(0));
        chk("d0 pixel_y after reset", 64'(py[0]), 64'(0));
        chk("d0 hsync after reset", 64'(hs[0]), 64'(1));
        for (int k = 0; k < 3; k++) begin
            step(3'b000, 3'($urandom));
            chk($sformatf("d0 no hsync glitch %0d", k), 64'(hs[0]), 64'(1));
        end

        n = 0;
        while (!((((c[2] + 1) / 3) % 25) == 19 && ((((c[2] + 1) / 3) / 25) % 11) == 7) && n < 1000) begin
            step(3'b000, 3'($urandom));
            n++;
        end
        chk("d2 reached sync region", 64'(n < 1000), 64'(1));
        step(3'b100, 3'($urandom));
        for (int k = 0; k < 5; k++) begin
            step(3'b000, 3'($urandom));
            chk($sformatf("d2 syncs idle after reset %0d", k), 64'({hs[2], vs[2]}), 64'(2'b11));
        end

        for (int k = 0; k < 3000; k++)
            step({$urandom_range(0, 499) == 0, $urandom_range(0, 499) == 0, $urandom_range(0, 499) == 0},
                 3'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
